// File: rtl/averager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : averager_pkg
// Description : Shared FSM state encoding and default widths for the
//               averager sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package averager_pkg;

    localparam int c_FAST_COUNT_WIDTH = 13;
    localparam int c_SLOW_COUNT_WIDTH = 19;
    localparam int c_ACQ_WIDTH        = 16;
    localparam int c_TIMER_WIDTH      = 32;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARM        = 3'd1,
        WAIT_ACK   = 3'd2,
        WAIT_READY = 3'd3,
        HOLDOFF    = 3'd4
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/averager_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : averager_sequencer_if
// Description : Control/status bundle between host, sequencer and averager.
// Revision    : 1.0 - initial release
// ============================================================================
interface averager_sequencer_if
    import averager_pkg::*;
#(
    parameter int FAST_COUNT_WIDTH = c_FAST_COUNT_WIDTH,
    parameter int SLOW_COUNT_WIDTH = c_SLOW_COUNT_WIDTH,
    parameter int ACQ_WIDTH        = c_ACQ_WIDTH,
    parameter int TIMER_WIDTH      = c_TIMER_WIDTH
) ();

    logic                        start;
    logic                        abort;
    logic [ACQ_WIDTH-1:0]        n_acq;
    logic [FAST_COUNT_WIDTH-1:0] cfg_count_max;
    logic                        cfg_avg_on;
    logic [TIMER_WIDTH-1:0]      holdoff;
    logic [TIMER_WIDTH-1:0]      timeout;
    logic                        avg_ready;
    logic [SLOW_COUNT_WIDTH-1:0] avg_n_avg;
    logic                        avg_restart;
    logic [FAST_COUNT_WIDTH-1:0] avg_count_max;
    logic                        avg_on;
    logic                        busy;
    logic                        done;
    logic [ACQ_WIDTH-1:0]        acq_count;
    logic [SLOW_COUNT_WIDTH-1:0] last_n_avg;
    logic                        timed_out;

    // master is the sequencer; slave is the host/averager environment
    modport master (
        input  start, abort, n_acq, cfg_count_max, cfg_avg_on, holdoff, timeout,
               avg_ready, avg_n_avg,
        output avg_restart, avg_count_max, avg_on, busy, done, acq_count,
               last_n_avg, timed_out
    );

    modport slave (
        output start, abort, n_acq, cfg_count_max, cfg_avg_on, holdoff, timeout,
               avg_ready, avg_n_avg,
        input  avg_restart, avg_count_max, avg_on, busy, done, acq_count,
               last_n_avg, timed_out
    );

endinterface
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : Loadable down-counter; a load of N flags expired in the Nth
//               enabled cycle (N=0 behaves as N=1).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer #(
    parameter int TIMER_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load_i,
    input  logic                   en_i,
    input  logic [TIMER_WIDTH-1:0] value_i,
    output logic                   expired_o
);

    localparam logic [TIMER_WIDTH-1:0] c_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

    logic [TIMER_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= (value_i == '0) ? '0 : value_i - c_ONE;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - c_ONE;
        end
    end

    assign expired_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/averager_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : averager_sequencer
// Description : Runs a sequence of averager acquisitions with restart
//               handshake, holdoff spacing, timeout and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module averager_sequencer
    import averager_pkg::*;
#(
    parameter int FAST_COUNT_WIDTH = c_FAST_COUNT_WIDTH,
    parameter int SLOW_COUNT_WIDTH = c_SLOW_COUNT_WIDTH,
    parameter int ACQ_WIDTH        = c_ACQ_WIDTH,
    parameter int TIMER_WIDTH      = c_TIMER_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    averager_sequencer_if.master bus
);

    localparam logic [ACQ_WIDTH-1:0] c_ACQ_ONE = {{(ACQ_WIDTH-1){1'b0}}, 1'b1};

    seq_state_e                  state_q;
    logic                        avg_restart_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        timed_out_q;
    logic                        avg_on_q;
    logic [FAST_COUNT_WIDTH-1:0] avg_count_max_q;
    logic [ACQ_WIDTH-1:0]        n_acq_q;
    logic [ACQ_WIDTH-1:0]        acq_count_q;
    logic [ACQ_WIDTH-1:0]        acq_count_d;
    logic [SLOW_COUNT_WIDTH-1:0] last_n_avg_q;

    logic w_ho_load, w_ho_en, w_ho_expired;
    logic w_to_load, w_to_en, w_to_expired;
    logic w_complete, w_last_acq, w_tmo_fire;

    // Timers are held loaded while idle so they start fresh on entry
    assign w_ho_load  = (state_q != HOLDOFF);
    assign w_ho_en    = (state_q == HOLDOFF);
    assign w_to_load  = (state_q == IDLE) || (state_q == HOLDOFF);
    assign w_to_en    = (state_q == ARM) || (state_q == WAIT_ACK) || (state_q == WAIT_READY);

    assign acq_count_d = acq_count_q + c_ACQ_ONE;
    assign w_complete  = (state_q == WAIT_READY) && bus.avg_ready;
    assign w_last_acq  = (n_acq_q != '0) && (acq_count_d == n_acq_q);
    assign w_tmo_fire  = w_to_en && w_to_expired && (bus.timeout != '0) && !w_complete;

    seq_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_holdoff_timer (
        .clk       (clk),
        .resetn    (resetn),
        .load_i    (w_ho_load),
        .en_i      (w_ho_en),
        .value_i   (bus.holdoff),
        .expired_o (w_ho_expired)
    );

    seq_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timeout_timer (
        .clk       (clk),
        .resetn    (resetn),
        .load_i    (w_to_load),
        .en_i      (w_to_en),
        .value_i   (bus.timeout),
        .expired_o (w_to_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            avg_restart_q   <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            timed_out_q     <= 1'b0;
            avg_on_q        <= 1'b0;
            avg_count_max_q <= '1;
            n_acq_q         <= '0;
            acq_count_q     <= '0;
            last_n_avg_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort && (state_q != IDLE)) begin
                state_q       <= IDLE;
                busy_q        <= 1'b0;
                avg_restart_q <= 1'b0;
            end else if (w_tmo_fire) begin
                state_q       <= IDLE;
                busy_q        <= 1'b0;
                avg_restart_q <= 1'b0;
                timed_out_q   <= 1'b1;
                done_q        <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            avg_count_max_q <= bus.cfg_count_max;
                            avg_on_q        <= bus.cfg_avg_on;
                            n_acq_q         <= bus.n_acq;
                            acq_count_q     <= '0;
                            timed_out_q     <= 1'b0;
                            busy_q          <= 1'b1;
                            state_q         <= ARM;
                        end
                    end
                    ARM: begin
                        avg_restart_q <= 1'b1;
                        state_q       <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (!bus.avg_ready) begin
                            avg_restart_q <= 1'b0;
                            state_q       <= WAIT_READY;
                        end
                    end
                    WAIT_READY: begin
                        if (bus.avg_ready) begin
                            last_n_avg_q <= bus.avg_n_avg;
                            acq_count_q  <= acq_count_d;
                            if (w_last_acq) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= HOLDOFF;
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (w_ho_expired) begin
                            state_q <= ARM;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.avg_restart   = avg_restart_q;
    assign bus.avg_count_max = avg_count_max_q;
    assign bus.avg_on        = avg_on_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.acq_count     = acq_count_q;
    assign bus.last_n_avg    = last_n_avg_q;
    assign bus.timed_out     = timed_out_q;

endmodule
`default_nettype wire

// File: tb/tb_averager_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_averager_sequencer
// Description : Directed bench for averager_sequencer with a latency-driven
//               averager model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_averager_sequencer;
    import averager_pkg::*;

    typedef struct {
        logic [c_ACQ_WIDTH-1:0]        n_acq;
        logic [c_TIMER_WIDTH-1:0]      holdoff;
        int                            lat;
        logic [c_FAST_COUNT_WIDTH-1:0] cmax;
        logic                          aon;
        logic [c_TIMER_WIDTH-1:0]      tmo;
        int                            exp_acq;
        logic                          exp_to;
        int                            exp_done;
        int                            exp_hs;
        logic                          chk_navg;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;

    averager_sequencer_if bus ();

    averager_sequencer u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Averager model: drops ready when restart is seen, re-readies m_lat cycles later
    int                           m_lat   = 0;
    logic                         m_stuck = 1'b0;
    int                           m_cnt   = 0;
    logic                         m_ready;
    logic [c_SLOW_COUNT_WIDTH-1:0] m_n_avg = 19'd100;

    assign bus.avg_ready = m_ready;
    assign bus.avg_n_avg = m_n_avg;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_ready <= 1'b1;
            m_cnt   <= 0;
        end else if (!m_stuck && bus.avg_restart) begin
            m_ready <= 1'b0;
            m_cnt   <= m_lat;
        end else if (!m_ready) begin
            if (m_cnt == 0) begin
                m_ready <= 1'b1;
                m_n_avg <= m_n_avg + 19'd7;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int                    done_cnt     = 0;
    int                    hs_cnt       = 0;
    logic                  prev_restart = 1'b0;
    logic [c_ACQ_WIDTH-1:0] prev_acq    = '0;
    logic [c_ACQ_WIDTH-1:0] acq_q[$];

    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.avg_restart === 1'b1 && !prev_restart) hs_cnt <= hs_cnt + 1;
        prev_restart <= bus.avg_restart;
        if (bus.acq_count !== prev_acq && bus.acq_count != '0) acq_q.push_back(bus.acq_count);
        prev_acq <= bus.acq_count;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int d0, h0, q0;
        bus.n_acq         = v.n_acq;
        bus.holdoff       = v.holdoff;
        bus.timeout       = v.tmo;
        bus.cfg_count_max = v.cmax;
        bus.cfg_avg_on    = v.aon;
        m_lat             = v.lat;
        d0 = done_cnt; h0 = hs_cnt; q0 = acq_q.size();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check($sformatf("v%0d busy_start", idx), bus.busy, 1);
        for (int i = 0; i < 5000 && bus.busy === 1'b1; i++) tick();
        check($sformatf("v%0d busy_end", idx), bus.busy, 0);
        repeat (3) tick();
        check($sformatf("v%0d acq_count", idx), bus.acq_count, v.exp_acq);
        check($sformatf("v%0d timed_out", idx), bus.timed_out, v.exp_to);
        check($sformatf("v%0d done_pulses", idx), done_cnt - d0, v.exp_done);
        check($sformatf("v%0d handshakes", idx), hs_cnt - h0, v.exp_hs);
        check($sformatf("v%0d count_max", idx), bus.avg_count_max, v.cmax);
        check($sformatf("v%0d avg_on", idx), bus.avg_on, v.aon);
        check($sformatf("v%0d restart_low", idx), bus.avg_restart, 0);
        if (v.chk_navg) check($sformatf("v%0d last_n_avg", idx), bus.last_n_avg, m_n_avg);
        check($sformatf("v%0d acq_seq_len", idx), acq_q.size() - q0, v.exp_acq);
        for (int k = 0; k < v.exp_acq; k++)
            if (q0 + k < acq_q.size())
                check($sformatf("v%0d acq_seq%0d", idx, k), acq_q[q0 + k], k + 1);
        repeat (50) tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   d0;
        int   ok;

        resetn = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.n_acq = '0;
        bus.cfg_count_max = '0; bus.cfg_avg_on = 1'b0;
        bus.holdoff = '0; bus.timeout = '0;

        //           n_acq holdoff lat  cmax      aon  tmo    acq to done hs navg
        vecs[0] = '{16'd3, 32'd10, 50, 13'h00FF, 1'b1, 32'd0,    3, 1'b0, 1, 3, 1'b1};
        vecs[1] = '{16'd1, 32'd5,   3, 13'h0123, 1'b0, 32'd0,    1, 1'b0, 1, 1, 1'b1};
        vecs[2] = '{16'd2, 32'd0,   0, 13'h1FFE, 1'b1, 32'd1000, 2, 1'b0, 1, 2, 1'b1};
        vecs[3] = '{16'd4, 32'd2,  20, 13'h0456, 1'b1, 32'd10,   0, 1'b1, 1, 1, 1'b0};

        tick(); tick();
        check("rst busy", bus.busy, 0);
        check("rst restart", bus.avg_restart, 0);
        check("rst done", bus.done, 0);
        check("rst timed_out", bus.timed_out, 0);
        check("rst acq_count", bus.acq_count, 0);
        check("rst last_n_avg", bus.last_n_avg, 0);
        check("rst count_max", bus.avg_count_max, 13'h1FFF);
        check("rst avg_on", bus.avg_on, 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // Timeout fires exactly 100 cycles after ARM entry when ready never drops
        bus.n_acq = 16'd1; bus.holdoff = '0; bus.timeout = 32'd100; m_stuck = 1'b1;
        d0 = done_cnt;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (99) tick();
        check("tmo before", bus.timed_out, 0);
        check("tmo busy_before", bus.busy, 1);
        tick();
        check("tmo flag", bus.timed_out, 1);
        check("tmo done", bus.done, 1);
        check("tmo busy", bus.busy, 0);
        check("tmo restart", bus.avg_restart, 0);
        tick();
        check("tmo done_single", bus.done, 0);
        repeat (5) tick();
        check("tmo sticky", bus.timed_out, 1);
        check("tmo done_count", done_cnt - d0, 1);
        m_stuck = 1'b0; bus.timeout = '0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("tmo cleared", bus.timed_out, 0);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        repeat (50) tick();

        // Free-running run aborted after 20 acquisitions
        bus.n_acq = '0; bus.holdoff = 32'd2; bus.timeout = '0; m_lat = 3;
        d0 = done_cnt;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (bus.acq_count == 16'd20) ok = 1;
            else tick();
        end
        check("free reached20", ok, 1);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        check("free busy", bus.busy, 0);
        check("free restart", bus.avg_restart, 0);
        check("free acq_count", bus.acq_count, 20);
        repeat (3) tick();
        check("free acq_hold", bus.acq_count, 20);
        check("free no_done", done_cnt - d0, 0);
        repeat (50) tick();

        // Start while busy is ignored; abort beats a simultaneous start
        bus.n_acq = '0; bus.holdoff = 32'd5; m_lat = 10;
        bus.cfg_count_max = 13'h00AA; bus.cfg_avg_on = 1'b1;
        d0 = done_cnt;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (3) tick();
        bus.cfg_count_max = 13'h0155; bus.cfg_avg_on = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("busy_start count_max", bus.avg_count_max, 13'h00AA);
        check("busy_start avg_on", bus.avg_on, 1);
        check("busy_start busy", bus.busy, 1);
        bus.start = 1'b1; bus.abort = 1'b1; tick();
        check("sa_run busy", bus.busy, 0);
        check("sa_run count_max", bus.avg_count_max, 13'h00AA);
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("sa_idle busy", bus.busy, 0);
        check("sa_idle count_max", bus.avg_count_max, 13'h00AA);
        check("sa no_done", done_cnt - d0, 0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("idle_start busy", bus.busy, 1);
        check("idle_start count_max", bus.avg_count_max, 13'h0155);
        check("idle_start avg_on", bus.avg_on, 0);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        repeat (50) tick();

        // holdoff=0: start latency and back-to-back ARM
        bus.n_acq = 16'd2; bus.holdoff = '0; bus.timeout = '0; m_lat = 5;
        bus.cfg_avg_on = 1'b1;
        d0 = done_cnt;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("lat restart_c1", bus.avg_restart, 0);
        tick();
        check("lat restart_c2", bus.avg_restart, 1);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bus.acq_count == 16'd1) ok = 1;
            else tick();
        end
        check("ho0 first_done", ok, 1);
        check("ho0 navg1", bus.last_n_avg, m_n_avg);
        check("ho0 restart_hold", bus.avg_restart, 0);
        tick();
        check("ho0 restart_arm", bus.avg_restart, 0);
        tick();
        check("ho0 restart_again", bus.avg_restart, 1);
        for (int i = 0; i < 300 && bus.busy === 1'b1; i++) tick();
        repeat (2) tick();
        check("ho0 acq_count", bus.acq_count, 2);
        check("ho0 navg2", bus.last_n_avg, m_n_avg);
        check("ho0 done", done_cnt - d0, 1);
        repeat (20) tick();

        // Asynchronous reset while waiting for the averager
        bus.n_acq = 16'd1; m_lat = 30;
        d0 = done_cnt;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!bus.avg_ready && bus.busy && !bus.avg_restart) ok = 1;
            else tick();
        end
        check("arst reached_wait", ok, 1);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("arst busy", bus.busy, 0);
        check("arst restart", bus.avg_restart, 0);
        check("arst done", bus.done, 0);
        check("arst timed_out", bus.timed_out, 0);
        check("arst acq_count", bus.acq_count, 0);
        check("arst last_n_avg", bus.last_n_avg, 0);
        check("arst count_max", bus.avg_count_max, 13'h1FFF);
        check("arst avg_on", bus.avg_on, 0);
        tick();
        resetn = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("arst no_done", done_cnt - d0, 0);
        check("arst first_start", bus.busy, 1);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        check("arst abort", bus.busy, 0);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/averager_sequencer.md
AVERAGER_SEQUENCER -- requirements
Module: averager_sequencer

Interface
REQ-001 SHALL have parameters: FAST_COUNT_WIDTH, default 13, averager fast-count width; SLOW_COUNT_WIDTH, default 19, averager n_avg width; ACQ_WIDTH, default 16, acquisition-count width; TIMER_WIDTH, default 32, holdoff/timeout width.
REQ-002 SHALL have ports (name direction width meaning):
- clk in 1: single clock.
- resetn in 1: asynchronous, active-low reset.
- start in 1: one-cycle pulse that begins a run.
- abort in 1: one-cycle pulse that ends a run.
- n_acq in ACQ_WIDTH: acquisitions per run; 0 means free-running.
- cfg_count_max in FAST_COUNT_WIDTH: record length minus 1.
- cfg_avg_on in 1: averaging enable.
- holdoff in TIMER_WIDTH: idle cycles between acquisitions.
- timeout in TIMER_WIDTH: cycles allowed per acquisition; 0 disables the timeout.
- avg_ready in 1: averager ready.
- avg_n_avg in SLOW_COUNT_WIDTH: averages from the last acquisition.
- avg_restart out 1: restart request to the averager.
- avg_count_max out FAST_COUNT_WIDTH: latched record length.
- avg_on out 1: latched averaging enable.
- busy out 1: high while a run is active.
- done out 1: one-cycle pulse at end of run.
- acq_count out ACQ_WIDTH: acquisitions completed.
- last_n_avg out SLOW_COUNT_WIDTH: captured avg_n_avg.
- timed_out out 1: sticky error flag.

Function
REQ-003 SHALL implement FSM states IDLE, ARM, WAIT_ACK, WAIT_READY, HOLDOFF.
REQ-004 IDLE + start: SHALL latch cfg_count_max, cfg_avg_on and n_acq; clear acq_count and timed_out; go to ARM on the next cycle; busy=1 from that cycle.
REQ-005 start while busy SHALL be ignored.
REQ-006 ARM/WAIT_ACK: avg_restart SHALL be 1, held level, not a pulse.
REQ-007 ARM SHALL go to WAIT_ACK after one cycle.
REQ-008 WAIT_ACK SHALL go to WAIT_READY on the first cycle avg_ready=0 (acknowledge); avg_restart SHALL drop in that transition cycle.
REQ-009 WAIT_READY on avg_ready=1 SHALL:
- capture avg_n_avg into last_n_avg;
- increment acq_count;
- if n_acq!=0 and incremented acq_count==n_acq: go to IDLE, busy=0, done=1 for exactly one cycle;
- else: go to HOLDOFF.
REQ-010 HOLDOFF SHALL count holdoff cycles and then go to ARM; holdoff=0 SHALL give ARM on the next cycle.
REQ-011 The timeout counter SHALL reload on entry to ARM and decrement in ARM, WAIT_ACK and WAIT_READY.
REQ-012 If timeout!=0 and the counter expires before REQ-009 triggers, the block SHALL set timed_out=1, go to IDLE, drop avg_restart, and pulse done.
REQ-013 timed_out SHALL clear only on an accepted start or on reset.
REQ-014 abort in any non-IDLE state SHALL:
- go to IDLE next cycle;
- deassert avg_restart and busy;
- leave acq_count unchanged;
- not pulse done.
REQ-015 If abort and start arrive in the same cycle, abort SHALL win; in IDLE, start alone is taken.
REQ-016 acq_count SHALL wrap modulo 2^ACQ_WIDTH in free-running mode.
REQ-017 avg_count_max and avg_on SHALL change only at start acceptance, never mid-run.
REQ-018 All outputs SHALL be registered; start to avg_restart=1 SHALL take 2 cycles.

Reset
REQ-019 On resetn=0, the block SHALL asynchronously force:
- state IDLE;
- avg_restart, busy, done, timed_out = 0;
- acq_count, last_n_avg = 0;
- avg_count_max = all ones;
- avg_on = 0;
- timers = 0.
REQ-020 Reset release SHALL be synchronous to clk; the first start SHALL be accepted on the first cycle after deassertion.
REQ-021 Reset mid-run SHALL drop avg_restart immediately, with no done pulse.

Structure
REQ-022 A shared package averager_pkg SHALL hold:
- the FSM state enum (IDLE, ARM, WAIT_ACK, WAIT_READY, HOLDOFF);
- default width constants matching REQ-001.
REQ-023 One sub-module, seq_timer, SHALL be used: a loadable TIMER_WIDTH down-counter with load, enable and expired outputs, instantiated twice (holdoff, timeout).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- n_acq=3, holdoff=10, averager model readies 50 cycles after ack -> three restart handshakes; acq_count 1,2,3; single done pulse; busy low after.
- n_acq=0, 20 acquisitions, abort -> acq_count=20; idle next cycle; no done pulse; avg_restart=0.
- timeout=100, model never drops avg_ready -> timed_out=1 and done pulse at 100 cycles after ARM entry; next start clears timed_out.
- Start while busy, plus start and abort in the same cycle -> no relatch of cfg_count_max; abort wins.
- resetn low during WAIT_READY -> all outputs at reset values asynchronously, including avg_count_max=all ones.
- holdoff=0, n_acq=2 -> second ARM entered the cycle after the first completion; last_n_avg equals the model's avg_n_avg.
